gpio_int_detect: RTL and testbench

GPIO_INT_DETECT -- requirements
Module: gpio_int_detect

---
 rtl/gpio_int_detect.sv | 120 ++++++++++++
 tb/tb_gpio_int_detect.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_int_detect.sv
// -----------------------------------------------------------------------------
// gpio_int_detect
//
// Per-line GPIO interrupt detector. Each line runs an optional debounce
// filter, then an edge/level detector that feeds a sticky (edge) or
// live (level) raw status bit. Status is masked combinationally and the
// masked bits are OR-reduced into a registered interrupt request.
//
// Parameters
//   DAT_W       number of GPIO interrupt lines
//   DB_W        width of the debounce counter and threshold
//
// Ports
//   des_clk     clock for all logic
//   des_rstn    asynchronous active-low reset
//   i_syn_dat   GPIO levels, already synchronized to des_clk
//   i_int_en    per-line interrupt enable
//   i_int_mask  per-line mask (1 = masked)
//   i_int_type  per-line mode (1 = edge, 0 = level)
//   i_int_pol   per-line polarity (1 = rising/high, 0 = falling/low)
//   i_both_edge per-line both-edge select in edge mode (overrides polarity)
//   i_db_en     debounce enable, common to all lines
//   i_db_cnt    debounce threshold
//   i_clr       write-1-to-clear pulse for edge-mode status
//   o_raw_stat  unmasked status register
//   o_int_stat  masked status (combinational)
//   o_irq       registered OR of o_int_stat
// -----------------------------------------------------------------------------
module gpio_int_detect #(
  parameter int DAT_W = 8,
  parameter int DB_W  = 4
) (
  input  logic             des_clk,
  input  logic             des_rstn,
  input  logic [DAT_W-1:0] i_syn_dat,
  input  logic [DAT_W-1:0] i_int_en,
  input  logic [DAT_W-1:0] i_int_mask,
  input  logic [DAT_W-1:0] i_int_type,
  input  logic [DAT_W-1:0] i_int_pol,
  input  logic [DAT_W-1:0] i_both_edge,
  input  logic             i_db_en,
  input  logic [DB_W-1:0]  i_db_cnt,
  input  logic [DAT_W-1:0] i_clr,
  output logic [DAT_W-1:0] o_raw_stat,
  output logic [DAT_W-1:0] o_int_stat,
  output logic             o_irq
);

  logic [DAT_W-1:0]           flt_q, flt_d;
  logic [DAT_W-1:0]           dly_q;
  logic [DAT_W-1:0][DB_W-1:0] cnt_q, cnt_d;
  logic [DAT_W-1:0]           raw_q, raw_d;
  logic                       irq_q, irq_d;
  logic [DAT_W-1:0]           evt;

  // Qualify a filtered-level change: both-edge accepts any change, otherwise
  // the new level must match the selected polarity.
  function automatic logic edge_hit(input logic cur, input logic prev,
                                    input logic pol, input logic both);
    return (cur != prev) && (both || (cur == pol));
  endfunction

  // Debounce filter. The threshold compare is >= rather than == so that a
  // threshold lowered mid-count still resolves instead of letting the
  // counter run on and wrap.
  always_comb begin
    flt_d = flt_q;
    cnt_d = '0;
    for (int i = 0; i < DAT_W; i++) begin
      if (!i_db_en) begin
        flt_d[i] = i_syn_dat[i];
      end else if (i_syn_dat[i] != flt_q[i]) begin
        if (cnt_q[i] >= i_db_cnt) begin
          flt_d[i] = i_syn_dat[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Status update. Edge mode is sticky with set taking priority over clear;
  // level mode simply tracks the filtered level and ignores clear.
  always_comb begin
    raw_d = raw_q;
    evt   = '0;
    for (int i = 0; i < DAT_W; i++) begin
      evt[i] = edge_hit(flt_q[i], dly_q[i], i_int_pol[i], i_both_edge[i]);
      if (!i_int_en[i]) begin
        raw_d[i] = 1'b0;
      end else if (i_int_type[i]) begin
        raw_d[i] = evt[i] | (raw_q[i] & ~i_clr[i]);
      end else begin
        raw_d[i] = (flt_q[i] == i_int_pol[i]);
      end
    end
  end

  assign o_int_stat = raw_q & ~i_int_mask;
  assign irq_d      = |o_int_stat;
  assign o_raw_stat = raw_q;
  assign o_irq      = irq_q;

  always_ff @(posedge des_clk or negedge des_rstn) begin
    if (!des_rstn) begin
      flt_q <= '0;
      dly_q <= '0;
      cnt_q <= '0;
      raw_q <= '0;
      irq_q <= 1'b0;
    end else begin
      flt_q <= flt_d;
      dly_q <= flt_q;
      cnt_q <= cnt_d;
      raw_q <= raw_d;
      irq_q <= irq_d;
    end
  end

endmodule

// File: tb/tb_gpio_int_detect.sv
module tb_gpio_int_detect;

  localparam int DW  = 8;
  localparam int DBW = 4;

  logic           des_clk  = 1'b0;
  logic           des_rstn = 1'b0;
  logic [DW-1:0]  i_syn_dat   = '0;
  logic [DW-1:0]  i_int_en    = '0;
  logic [DW-1:0]  i_int_mask  = '0;
  logic [DW-1:0]  i_int_type  = '0;
  logic [DW-1:0]  i_int_pol   = '0;
  logic [DW-1:0]  i_both_edge = '0;
  logic           i_db_en     = 1'b0;
  logic [DBW-1:0] i_db_cnt    = '0;
  logic [DW-1:0]  i_clr       = '0;
  logic [DW-1:0]  o_raw_stat;
  logic [DW-1:0]  o_int_stat;
  logic           o_irq;

  int total = 0;
  int bad   = 0;

  gpio_int_detect #(.DAT_W(DW), .DB_W(DBW)) dut (
    .des_clk     (des_clk),
    .des_rstn    (des_rstn),
    .i_syn_dat   (i_syn_dat),
    .i_int_en    (i_int_en),
    .i_int_mask  (i_int_mask),
    .i_int_type  (i_int_type),
    .i_int_pol   (i_int_pol),
    .i_both_edge (i_both_edge),
    .i_db_en     (i_db_en),
    .i_db_cnt    (i_db_cnt),
    .i_clr       (i_clr),
    .o_raw_stat  (o_raw_stat),
    .o_int_stat  (o_int_stat),
    .o_irq       (o_irq)
  );

  always #5 des_clk = ~des_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge des_clk);
      #1;
    end
  endtask

  // Reference model: debounce as a run length of consecutive samples that
  // disagree with the filtered level; events from explicit rise/fall terms.
  logic [DW-1:0] m_flt, m_prev, m_raw;
  logic          m_irq;
  int            m_run [DW];

  always @(posedge des_clk or negedge des_rstn) begin
    if (!des_rstn) begin
      m_flt  <= '0;
      m_prev <= '0;
      m_raw  <= '0;
      m_irq  <= 1'b0;
      for (int i = 0; i < DW; i++) m_run[i] <= 0;
    end else begin
      m_irq  <= |(m_raw & ~i_int_mask);
      m_prev <= m_flt;
      for (int i = 0; i < DW; i++) begin
        automatic bit rise = m_flt[i] & ~m_prev[i];
        automatic bit fall = ~m_flt[i] & m_prev[i];
        automatic bit hit  = i_both_edge[i] ? (rise | fall)
                                            : (i_int_pol[i] ? rise : fall);
        if (!i_int_en[i])        m_raw[i] <= 1'b0;
        else if (!i_int_type[i]) m_raw[i] <= (m_flt[i] == i_int_pol[i]);
        else if (hit)            m_raw[i] <= 1'b1;
        else if (i_clr[i])       m_raw[i] <= 1'b0;

        if (!i_db_en) begin
          m_flt[i] <= i_syn_dat[i];
          m_run[i] <= 0;
        end else if (i_syn_dat[i] == m_flt[i]) begin
          m_run[i] <= 0;
        end else if (m_run[i] + 1 > int'(i_db_cnt)) begin
          m_flt[i] <= i_syn_dat[i];
          m_run[i] <= 0;
        end else begin
          m_run[i] <= m_run[i] + 1;
        end
      end
    end
  end

  always @(negedge des_clk) begin
    chk("cyc_raw",  32'(o_raw_stat), 32'(m_raw));
    chk("cyc_int",  32'(o_int_stat), 32'(m_raw & ~i_int_mask));
    chk("cyc_irq",  32'(o_irq),      32'(m_irq));
  end

  initial begin
    // reset state
    step(2);
    chk("rst_raw", 32'(o_raw_stat), 32'h0);
    chk("rst_irq", 32'(o_irq), 32'h0);
    des_rstn = 1'b1;

    // basic rising edge, debounce off
    i_int_en = 8'h01; i_int_type = 8'h01; i_int_pol = 8'h01;
    step(2);
    i_syn_dat[0] = 1'b1;
    step(1); chk("e_n1_raw", 32'(o_raw_stat), 32'h00);
    step(1); chk("e_n2_raw", 32'(o_raw_stat), 32'h01);
             chk("e_n2_irq", 32'(o_irq), 32'h0);
             chk("e_n2_mraw", 32'(m_raw), 32'h01);
    step(1); chk("e_n3_irq", 32'(o_irq), 32'h1);
    i_clr = 8'h01; step(1); i_clr = 8'h00;
    chk("e_clr_raw", 32'(o_raw_stat), 32'h00);
    step(1); chk("e_clr_irq", 32'(o_irq), 32'h0);

    // debounce: 3-cycle glitch rejected, 4-cycle hold accepted
    i_syn_dat[0] = 1'b0; step(2);
    i_db_en = 1'b1; i_db_cnt = 4'd3; step(1);
    i_syn_dat[0] = 1'b1; step(3);
    i_syn_dat[0] = 1'b0; step(3);
    chk("db_glitch", 32'(o_raw_stat), 32'h00);
    i_syn_dat[0] = 1'b1; step(4);
    chk("db_flt", 32'(dut.flt_q[0]), 32'h1);
    chk("db_hold4", 32'(o_raw_stat), 32'h00);
    step(1); chk("db_hold5", 32'(o_raw_stat), 32'h01);
    i_clr = 8'h01; step(1); i_clr = 8'h00;
    i_db_en = 1'b0; step(2);
    chk("db_clr", 32'(o_raw_stat), 32'h00);

    // level mode, low polarity, bit3
    i_int_en[3] = 1'b1; i_int_type[3] = 1'b0; i_int_pol[3] = 1'b0;
    step(1); chk("lv_set", 32'(o_raw_stat), 32'h08);
    i_clr = 8'h08; step(1); i_clr = 8'h00;
    chk("lv_noclr", 32'(o_raw_stat), 32'h08);
    i_syn_dat[3] = 1'b1;
    step(1); chk("lv_hi1", 32'(o_raw_stat), 32'h08);
    step(1); chk("lv_hi2", 32'(o_raw_stat), 32'h00);
    i_int_en[3] = 1'b0;

    // both edges on bit1
    i_syn_dat[1] = 1'b1; step(3);
    i_int_en[1] = 1'b1; i_int_type[1] = 1'b1; i_both_edge[1] = 1'b1;
    step(2); chk("be_idle", 32'(o_raw_stat), 32'h00);
    i_syn_dat[1] = 1'b0; step(2);
    chk("be_fall", 32'(o_raw_stat), 32'h02);
    i_clr = 8'h02; step(1); i_clr = 8'h00;
    chk("be_clr1", 32'(o_raw_stat), 32'h00);
    i_syn_dat[1] = 1'b1; step(2);
    chk("be_rise", 32'(o_raw_stat), 32'h02);
    i_clr = 8'h02; step(1); i_clr = 8'h00;
    step(1); chk("be_clr2", 32'(o_raw_stat), 32'h00);
    i_syn_dat[1] = 1'b0; step(1);
    i_clr = 8'h02; step(1); i_clr = 8'h00;
    chk("be_setwins", 32'(o_raw_stat), 32'h02);
    i_clr = 8'h02; step(1); i_clr = 8'h00;
    chk("be_clr3", 32'(o_raw_stat), 32'h00);

    // masking on bit2
    i_int_mask = 8'hFF;
    i_int_en[2] = 1'b1; i_int_type[2] = 1'b1; i_int_pol[2] = 1'b1;
    step(1);
    i_syn_dat[2] = 1'b1; step(2);
    chk("mk_raw", 32'(o_raw_stat), 32'h04);
    chk("mk_int", 32'(o_int_stat), 32'h00);
    step(2); chk("mk_irq", 32'(o_irq), 32'h0);
    i_int_mask = 8'h00; #1;
    chk("um_int", 32'(o_int_stat), 32'h04);
    chk("um_irq0", 32'(o_irq), 32'h0);
    step(1); chk("um_irq1", 32'(o_irq), 32'h1);

    // async reset mid-debounce, then lines held high
    i_syn_dat[0] = 1'b0; step(2);
    i_syn_dat[0] = 1'b1; step(2);
    chk("rs_raw05", 32'(o_raw_stat), 32'h05);
    i_db_en = 1'b1; i_db_cnt = 4'd3; i_syn_dat[0] = 1'b0; step(2);
    chk("rs_cnt2", 32'(dut.cnt_q[0]), 32'd2);
    chk("rs_raw05b", 32'(o_raw_stat), 32'h05);
    des_rstn = 1'b0; #1;
    chk("rs_raw0", 32'(o_raw_stat), 32'h00);
    chk("rs_int0", 32'(o_int_stat), 32'h00);
    chk("rs_irq0", 32'(o_irq), 32'h0);
    chk("rs_cnt0", 32'(dut.cnt_q[0]), 32'd0);
    chk("rs_flt0", 32'(dut.flt_q), 32'h00);
    i_syn_dat = 8'h05;
    @(posedge des_clk); #1;
    des_rstn = 1'b1;
    step(4); chk("rl_4", 32'(o_raw_stat), 32'h00);
    step(1); chk("rl_5", 32'(o_raw_stat), 32'h05);
    step(1); chk("rl_irq", 32'(o_irq), 32'h1);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
